// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned INSTR_BYTES = 2;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALTED  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO of fetched {instruction, pc}; slot0 is always the head,
// so head data and head_valid come straight from flops.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t slot0_q, slot1_q, slot0_n, slot1_n;
  logic [1:0]   count_q, count_n;
  logic         pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
    slot0_n = slot0_q;
    slot1_n = slot1_q;
    count_n = count_q;
    if (flush) begin
      count_n = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) slot0_n = push_entry;
          else                 slot1_n = push_entry;
          count_n = count_q + 2'd1;
        end
        2'b01: begin
          slot0_n = slot1_q;
          count_n = count_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new entry lands behind whatever remains
          if (count_q == 2'd1) begin
            slot0_n = push_entry;
          end else begin
            slot0_n = slot1_q;
            slot1_n = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      count_q    <= 2'd0;
      head_valid <= 1'b0;
    end else begin
      slot0_q    <= slot0_n;
      slot1_q    <= slot1_n;
      count_q    <= count_n;
      head_valid <= (count_n != 2'd0);
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding halfword requests to memory, 2-entry
// buffer toward decode, branch redirect with stale-response discard, and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instruction,
  output logic [31:0] PC_out,
  output logic        valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt
);

  localparam logic [ADDR_W-1:0] PC_MASK     = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & PC_MASK;
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(INSTR_BYTES);
  localparam logic [1:0]        FIFO_FULL   = 2'(DEPTH);

  fetch_state_e      state_q, state_n;
  logic              mem_req_q, mem_req_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic              halt_pend_q, halt_pend_n;

  logic              hold, done, pop, push, flush, issue;
  logic [1:0]        occ, occ_n;
  fetch_entry_t      push_entry, head;
  logic              head_valid;

  assign hold = mem_req_q && !mem_ready;
  assign done = mem_req_q && mem_ready;
  assign pop  = head_valid && !stall;

  assign push_entry.instr = mem_rdata;
  assign push_entry.pc    = mem_addr_q;

  // next-state, redirect and request issue
  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    halt_pend_n = halt_pend_q;
    push        = 1'b0;
    flush       = 1'b0;
    mem_req_n   = hold;
    mem_addr_n  = mem_addr_q;
    occ_n       = occ;
    issue       = 1'b0;

    case (state_q)
      FETCH: begin
        if (halt || halt_pend_q) begin
          halt_pend_n = 1'b1;
          push        = done;
          if (!hold) state_n = HALTED;
        end else if (branch_taken) begin
          flush = 1'b1;
          pc_n  = branch_target & PC_MASK;
          if (hold) state_n = DISCARD;
        end else begin
          push = done;
        end
      end
      DISCARD: begin
        // the in-flight response belongs to the old path and is never buffered
        if (halt || halt_pend_q) begin
          halt_pend_n = 1'b1;
          if (!hold) state_n = HALTED;
        end else begin
          if (branch_taken) begin
            flush = 1'b1;
            pc_n  = branch_target & PC_MASK;
          end
          if (!hold) state_n = FETCH;
        end
      end
      HALTED: ;
      default: state_n = FETCH;
    endcase

    if (flush) occ_n = 2'd0;
    else       occ_n = 2'(occ + {1'b0, push} - {1'b0, pop});

    issue = (state_n == FETCH) && !halt_pend_n && !hold && (occ_n < FIFO_FULL);
    if (issue) begin
      mem_req_n  = 1'b1;
      mem_addr_n = pc_n;
      pc_n       = pc_n + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= RESET_PC_AL;
      pc_q        <= RESET_PC_AL;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      mem_req_q   <= mem_req_n;
      mem_addr_q  <= mem_addr_n;
      pc_q        <= pc_n;
      halt_pend_q <= halt_pend_n;
    end
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .head_valid (head_valid),
    .count      (occ)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instruction = head.instr;
  assign PC_out      = head.pc;
  assign valid       = head_valid;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (bit 0 ignored).
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries (fixed at 2 in this revision).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  fetch request to instruction memory.
REQ-006 mem_addr  output  32  halfword address of the request; bit 0 always 0.
REQ-007 mem_ready  input  1  memory accepts and completes the request this cycle.
REQ-008 mem_rdata  input  16  instruction halfword; valid only when mem_req && mem_ready.
REQ-009 instruction  output  16  oldest buffered instruction, to decode.
REQ-010 PC_out  output  32  address of the instruction on the instruction output, to decode PC_in.
REQ-011 valid  output  1  instruction and PC_out hold a real entry.
REQ-012 stall  input  1  decode cannot accept this cycle.
REQ-013 branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-014 branch_target  input  32  redirect address; bit 0 forced to 0 internally.
REQ-015 halt  input  1  undefined instruction seen (decode explose); stops fetching.

Function
REQ-016 Memory handshake SHALL be: mem_req and mem_addr held stable from assertion until the cycle mem_ready is high; at most one outstanding request; completion when mem_req && mem_ready.
REQ-017 A new request SHALL be issued only when buffer occupancy plus outstanding requests is less than 2, state is FETCH, and no flush or halt is active that cycle.
REQ-018 Back-to-back requests SHALL be allowed: mem_req may stay high across a completion, with mem_addr advancing by 2.
REQ-019 Fetch address SHALL increment by 2 per completed, non-discarded request, wrapping 32'hFFFF_FFFE -> 32'h0000_0000.
REQ-020 Buffer SHALL be a 2-entry FIFO of {instruction, address}; a completed response is written the same cycle.
REQ-021 The head entry SHALL be popped when valid && !stall; a simultaneous pop and push SHALL keep occupancy unchanged.
REQ-022 The instruction, PC_out and valid outputs SHALL be registered from the FIFO head, so they are available one cycle after the response completes.
REQ-023 States SHALL be FETCH, DISCARD and HALTED.
REQ-024 On branch_taken in FETCH: flush the FIFO (valid=0 next cycle) and load the fetch address with branch_target.
REQ-025 After that branch, with no request outstanding: next state is FETCH, and the first request is to the target the next cycle.
REQ-026 After that branch, with a request outstanding that does not complete that cycle: next state is DISCARD.
REQ-027 In DISCARD, the outstanding request SHALL be held until mem_ready; its data is dropped, and the state then returns to FETCH.
REQ-028 branch_taken in DISCARD SHALL replace the pending target; the state stays DISCARD.
REQ-029 branch_taken in the same cycle as a completion SHALL drop that response.
REQ-030 On halt: stop issuing requests; an outstanding request completes normally and is buffered; then enter HALTED.
REQ-031 In HALTED, already-buffered entries still drain to decode; only reset exits HALTED.
REQ-032 halt and branch_taken in the same cycle: halt SHALL win and the branch is ignored.
REQ-033 stall SHALL never block the memory handshake; a full FIFO only suppresses new requests.

Reset
REQ-034 While reset is high, outputs SHALL be: mem_req=0, mem_addr=RESET_PC, valid=0, instruction=0, PC_out=0.
REQ-035 While reset is high: FIFO empty, state FETCH, nothing outstanding.
REQ-036 Reset mid-request SHALL abandon the request with no wait for mem_ready.
REQ-037 mem_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-038 The shared core package SHALL hold: the state enum (FETCH/DISCARD/HALTED), the fetch-entry struct {instr[15:0], pc[31:0]} and the INSTR_BYTES=2 constant.
REQ-039 The FIFO SHALL be one sub-module, fetch_buffer (push/pop/flush, 2 entries, count output).

Verification
REQ-040 Reset release, mem_ready always 1, stall=0 -> addresses 0,2,4,6 issued on consecutive cycles; decode sees valid with PC_out 0,2,4 each one cycle after completion.
REQ-041 stall=1 for 5 cycles -> FIFO fills to 2, mem_req deasserts, head held stable; stall release -> entries at 0 and 2 delivered in order, fetch resumes at 4.
REQ-042 mem_ready held 0 for 3 cycles, then branch_taken with target 0x100 -> DISCARD, old data dropped after mem_ready; next request addr 0x100; no stale valid.
REQ-043 RESET_PC=32'hFFFF_FFFC, no stall -> PC_out sequence FFFF_FFFC, FFFF_FFFE, 0000_0000.
REQ-044 halt and branch_taken (target 0x40) in the same cycle with one outstanding request -> request completes and is buffered, HALTED, 0x40 never requested; reset then refetches RESET_PC.
REQ-045 Assert reset during an outstanding request -> mem_req=0 next cycle; a late mem_ready has no effect; fetch restarts at RESET_PC.
